// File: rtl/simd_fetch.sv
// simd_fetch -- instruction fetch stage feeding the SIMD decoder.
//
// On start, words are read from a synchronous instruction memory beginning at
// start_pc and pushed into a 2-entry FIFO. The decoder reads that FIFO over a
// valid/ready handshake. Fetching stops after a return word has been fetched.
// done pulses when the decoder accepts that return word.
//
// Handshake: a word moves from the FIFO head to the decoder in any cycle where
// instr_valid and instr_ready are both high. While instr_valid is high and
// instr_ready is low, instruction and instr_pc hold steady.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, start_pc     begin a fetch stream at start_pc (sampled only in IDLE)
//   busy, done          busy outside IDLE; done pulses when the return word is accepted
//   imem_req/imem_addr  memory read request and word address
//   imem_rdata          memory read data, valid one cycle after imem_req
//   instr_valid/ready   FIFO head handshake to the decoder
//   instruction         FIFO head word
//   instr_pc            word address of the FIFO head
module simd_fetch #(
    parameter int IMEM_AW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [IMEM_AW-1:0] start_pc,
    output logic               busy,
    output logic               done,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [31:0]        instruction,
    output logic [IMEM_AW-1:0] instr_pc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [IMEM_AW-1:0] pc;
    logic [IMEM_AW-1:0] req_addr;   // address of the read currently in flight
    logic               outst;
    logic               stop_q;
    logic               ret_now;
    logic               stop;
    logic               push;
    logic               pop;
    logic [1:0]         count;
    logic               wptr, rptr;
    logic [31:0]        fifo_word [2];
    logic [IMEM_AW-1:0] fifo_pc   [2];
    logic [2:0]         occupancy;

    // A return word is anything the decoder does not recognise.
    function automatic logic is_return(input logic [31:0] w);
        logic known;
        known = 1'b0;
        case (w[31:21])
            11'b10001011000,                 // ADD
            11'b11001011000,                 // SUB
            11'b10011011000,                 // MUL
            11'b10011010110,                 // UDIV
            11'b10101010101: known = 1'b1;   // LOAD
            11'b00011110011:                 // FADD / FSUB
                known = (w[15:10] == 6'b001010) || (w[15:10] == 6'b001110);
            default:         known = 1'b0;
        endcase
        return !known;
    endfunction

    // Data returning after the return word (stop_q set) is dropped.
    assign ret_now   = (state == RUN) & outst & ~stop_q & is_return(imem_rdata);
    assign stop      = stop_q | ret_now;
    assign push      = outst & ~stop_q;
    assign pop       = instr_valid & instr_ready;

    // Words already owned (stored or in flight) must stay within the 2 slots,
    // counting the slot freed by a pop in this same cycle.
    assign occupancy = {1'b0, count} + {2'b00, outst};
    assign imem_req  = (state == RUN) & ~stop & (occupancy < (3'd2 + {2'b00, pop}));
    assign imem_addr = pc;

    // In DRAIN nothing is pushed, so the last remaining entry is the return word.
    assign done        = (state == DRAIN) & pop & (count == 2'd1);
    assign busy        = (state != IDLE);
    assign instr_valid = (count != 2'd0);
    assign instruction = instr_valid ? fifo_word[rptr] : '0;
    assign instr_pc    = instr_valid ? fifo_pc[rptr]   : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)   state_nxt = RUN;
            RUN:     if (ret_now) state_nxt = DRAIN;
            DRAIN:   if (done)    state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= '0;
            req_addr <= '0;
            outst    <= 1'b0;
            stop_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            outst <= imem_req;
            if (imem_req) req_addr <= pc;
            if (state == IDLE && start) pc <= start_pc;
            else if (imem_req)          pc <= pc + 1'b1;
            if (state == IDLE)  stop_q <= 1'b0;
            else if (ret_now)   stop_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_word[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else begin
            if (push) begin
                fifo_word[wptr] <= imem_rdata;
                fifo_pc[wptr]   <= req_addr;
                wptr            <= ~wptr;
            end
            if (pop) rptr <= ~rptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
